regfile_mp: RTL

- Parametrised successor to the core's 2-read/1-write integer register file.
- Adds configurable data width, register count and read-port count.
- Adds same-cycle write-to-read bypass and a hardware clear sequencer, so the array is deterministically zeroed after reset and on request.
- Sits in the decode/writeback stage of the pipeline.
- The optional scoreboard gives the hazard unit per-register pending bits.

---
 rtl/regfile_mp_pkg.sv | 29 ++
 rtl/regfile_mp_rdport.sv | 40 ++++
 rtl/regfile_mp.sv | 111 +++++++++++
 3 files changed

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared state encoding and packed-port slicing helper for regfile_mp.
// Rev 1.0 - initial release.
`default_nettype none

package regfile_mp_pkg;

   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] RUN   = 1'b1;

   localparam int MAX_VEC   = 256;
   localparam int MAX_SLICE = 32;

   // Returns bits [idx*w +: w] of vec, zero-extended to MAX_SLICE bits.
   function automatic logic [MAX_SLICE-1:0] port_slice(input logic [MAX_VEC-1:0] vec,
                                                       input int idx,
                                                       input int w);
      logic [MAX_VEC-1:0]   sh;
      logic [MAX_SLICE-1:0] r;
      sh = vec >> (idx * w);
      r  = '0;
      for (int b = 0; b < MAX_SLICE; b++) begin
         if (b < w) r[b] = sh[b];
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_rdport.sv
// regfile_mp_rdport: one read port with zero-register, enable and same-cycle bypass muxing.
// Rev 1.0 - initial release.
`default_nettype none

module regfile_mp_rdport #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              en,
   input  logic              valid,
   input  logic [ADDR_W-1:0] addr,
   input  logic              fwd_en,
   input  logic [ADDR_W-1:0] fwd_addr,
   input  logic [DATA_W-1:0] fwd_data,
   input  logic [DATA_W-1:0] row,
   output logic [DATA_W-1:0] data
);

   logic zero_hit;
   logic byp_hit;

   assign zero_hit = (ZERO_REG != 0) && (addr == '0);
   assign byp_hit  = (BYPASS != 0) && fwd_en && (fwd_addr == addr);

   always_comb begin
      data = '0;
      if (!en || !valid || zero_hit) begin
         data = '0;
      end else if (byp_hit) begin
         data = fwd_data;
      end else begin
         data = row;
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with bypass and hardware clear.
// Optional per-register pending scoreboard enabled by REGFILE_MP_SCOREBOARD_EN. Rev 1.0.
`default_nettype none

module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter  int DATA_W   = 32,
   parameter  int NUM_REGS = 32,
   parameter  int NUM_RD   = 2,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
`ifdef REGFILE_MP_SCOREBOARD_EN
   input  logic                     sb_set_en,
   input  logic [ADDR_W-1:0]        sb_set_addr,
   output logic [NUM_RD-1:0]        rd_busy,
`endif
   input  logic                     clear_req,
   output logic                     ready
);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [0:0]        state;
   logic [ADDR_W-1:0] clr_idx;
   logic              wr_acc;
   logic              rd_valid;

   // A write is only accepted in RUN, and a concurrent clear request wins over it.
   assign wr_acc   = !rst && ready && (state == RUN) && wr_en && !clear_req &&
                     !((ZERO_REG != 0) && (wr_addr == '0));
   assign rd_valid = ready && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_idx <= '0;
         ready   <= 1'b0;
      end else if (state == CLEAR) begin
         regs[clr_idx] <= '0;
         clr_idx       <= clr_idx + 1'b1;
         if (&clr_idx) begin
            state <= RUN;
            ready <= 1'b1;
         end
      end else begin
         if (clear_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
         end else if (wr_acc) begin
            regs[wr_addr] <= wr_data;
         end
      end
   end

`ifdef REGFILE_MP_SCOREBOARD_EN
   logic [NUM_REGS-1:0] pending;

   // Set is applied after clear so a same-cycle re-issue stays pending.
   always_ff @(posedge clk) begin
      if (rst || (state == CLEAR)) begin
         pending <= '0;
      end else begin
         if (wr_acc) pending[wr_addr] <= 1'b0;
         if (sb_set_en && !((ZERO_REG != 0) && (sb_set_addr == '0)))
            pending[sb_set_addr] <= 1'b1;
      end
   end
`endif

   generate
      for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
         logic [ADDR_W-1:0] addr;
         assign addr = ADDR_W'(port_slice(MAX_VEC'(rd_addr), i, ADDR_W));

         regfile_mp_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
         ) u_rdport (
            .en       (rd_en[i]),
            .valid    (rd_valid),
            .addr     (addr),
            .fwd_en   (wr_acc),
            .fwd_addr (wr_addr),
            .fwd_data (wr_data),
            .row      (regs[addr]),
            .data     (rd_data[i*DATA_W +: DATA_W])
         );

`ifdef REGFILE_MP_SCOREBOARD_EN
         assign rd_busy[i] = pending[addr] && rd_en[i] && rd_valid &&
                             !((BYPASS != 0) && wr_acc && (wr_addr == addr));
`endif
      end
   endgenerate

endmodule

`default_nettype wire
